// File: rtl/cordic_autoscale_ctrl_pkg.sv
// Shared types and constants for the CORDIC autoscale controller.
// Holds the FSM state encoding and the target MSB position for normalisation.
package cordic_autoscale_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIND  = 2'd1,
        SHIFT = 2'd2,
        OUT   = 2'd3
    } state_t;

    localparam int DEFAULT_DIN_WIDTH = 16;

    // Largest magnitude bit lands just below the sign bit.
    localparam int MSB_TARGET = DEFAULT_DIN_WIDTH - 2;

    function automatic int msb_target(input int din_width);
        return din_width - 2;
    endfunction

endpackage

// File: rtl/cordic_autoscale_ctrl_lead_one_encoder.sv
// Registered highest-set-bit encoder with zero flag, one cycle of latency.
// Loads only when en is high so the result stays valid for the SHIFT stage.
module lead_one_encoder #(
    parameter int DIN_WIDTH   = 16,
    parameter int SHIFT_WIDTH = $clog2(DIN_WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [DIN_WIDTH-1:0]   din,
    output logic [SHIFT_WIDTH-1:0] pos,
    output logic                   zero
);

    logic [SHIFT_WIDTH-1:0] pos_c;

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        pos_c = '0;
        for (int i = 0; i < DIN_WIDTH; i++) begin
            if (din[i]) pos_c = SHIFT_WIDTH'(i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos  <= '0;
            zero <= 1'b0;
        end else if (en) begin
            pos  <= pos_c;
            zero <= (din == '0);
        end
    end

endmodule

// File: rtl/cordic_autoscale_ctrl.sv
// Autoscale sequencer: normalises a signed (x, y) pair by a common left shift.
// Optional AUTOSCALE_BYPASS_EN adds a 'bypass' input that forces a zero shift.
module cordic_autoscale_ctrl
    import cordic_autoscale_ctrl_pkg::*;
#(
    parameter int DIN_WIDTH   = DEFAULT_DIN_WIDTH,
    parameter int SHIFT_WIDTH = $clog2(DIN_WIDTH)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [DIN_WIDTH-1:0] s_x,
    input  logic signed [DIN_WIDTH-1:0] s_y,
    input  logic                        s_valid,
    output logic                        s_ready,
`ifdef AUTOSCALE_BYPASS_EN
    input  logic                        bypass,
`endif
    output logic signed [DIN_WIDTH-1:0] m_x,
    output logic signed [DIN_WIDTH-1:0] m_y,
    output logic [SHIFT_WIDTH-1:0]      m_shift,
    output logic                        m_zero,
    output logic                        m_valid,
    input  logic                        m_ready
);

    localparam int TARGET = msb_target(DIN_WIDTH);

    state_t                  state, state_nxt;
    logic                    init_done;
    logic signed [DIN_WIDTH-1:0] x_q, y_q;
    logic [DIN_WIDTH-1:0]    mag_q;
    logic [SHIFT_WIDTH-1:0]  lead_pos;
    logic                    lead_zero;
    logic [SHIFT_WIDTH-1:0]  shift_c;
    logic                    accept;
    logic                    bypass_q;

    // |-2^(N-1)| wraps to 2^(N-1) in N unsigned bits, which is the wanted value.
    function automatic logic [DIN_WIDTH-1:0] mag_of(input logic signed [DIN_WIDTH-1:0] v);
        return v[DIN_WIDTH-1] ? $unsigned(~v + 1'b1) : $unsigned(v);
    endfunction

    assign s_ready = (state == IDLE) && init_done;
    assign m_valid = (state == OUT);
    assign accept  = s_valid && s_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            init_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            init_done <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)  state_nxt = FIND;
            FIND:                 state_nxt = SHIFT;
            SHIFT:                state_nxt = OUT;
            OUT:     if (m_ready) state_nxt = IDLE;
            default:              state_nxt = IDLE;
        endcase
    end

    lead_one_encoder #(
        .DIN_WIDTH   (DIN_WIDTH),
        .SHIFT_WIDTH (SHIFT_WIDTH)
    ) u_lead_one (
        .clk  (clk),
        .rst  (rst),
        .en   (state == FIND),
        .din  (mag_q),
        .pos  (lead_pos),
        .zero (lead_zero)
    );

    // A leading one already in the sign position (only from -2^(N-1)) is left unshifted.
    always_comb begin
        shift_c = '0;
        if (!lead_zero && lead_pos != SHIFT_WIDTH'(DIN_WIDTH - 1))
            shift_c = SHIFT_WIDTH'(TARGET) - lead_pos;
        if (bypass_q) shift_c = '0;
    end

`ifdef AUTOSCALE_BYPASS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         bypass_q <= 1'b0;
        else if (accept) bypass_q <= bypass;
    end
`else
    assign bypass_q = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q     <= '0;
            y_q     <= '0;
            mag_q   <= '0;
            m_x     <= '0;
            m_y     <= '0;
            m_shift <= '0;
            m_zero  <= 1'b0;
        end else begin
            if (accept) begin
                x_q   <= s_x;
                y_q   <= s_y;
                mag_q <= mag_of(s_x) | mag_of(s_y);
            end
            if (state == SHIFT) begin
                m_x     <= x_q <<< shift_c;
                m_y     <= y_q <<< shift_c;
                m_shift <= shift_c;
                m_zero  <= lead_zero;
            end
        end
    end

endmodule

// File: tb/tb_cordic_autoscale_ctrl.sv
// Self-checking bench for cordic_autoscale_ctrl: directed and random pairs,
// backpressure and mid-operation reset, with a queue-based scoreboard.
module tb_cordic_autoscale_ctrl;

    typedef struct {
        logic signed [15:0] x;
        logic signed [15:0] y;
        logic [3:0]         shift;
        logic               zero;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [15:0] s_x, s_y;
    logic               s_valid;
    logic               s_ready;
    logic signed [15:0] m_x, m_y;
    logic [3:0]         m_shift;
    logic               m_zero;
    logic               m_valid;
    logic               m_ready;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    cordic_autoscale_ctrl #(.DIN_WIDTH(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .s_x     (s_x),
        .s_y     (s_y),
        .s_valid (s_valid),
        .s_ready (s_ready),
`ifdef AUTOSCALE_BYPASS_EN
        .bypass  (1'b0),
`endif
        .m_x     (m_x),
        .m_y     (m_y),
        .m_shift (m_shift),
        .m_zero  (m_zero),
        .m_valid (m_valid),
        .m_ready (m_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Normalise by doubling until the combined magnitude reaches 2^14.
    function automatic exp_t model(input logic signed [15:0] x, input logic signed [15:0] y);
        exp_t e;
        int ax, ay, m, s;
        ax = (x < 0) ? -int'(x) : int'(x);
        ay = (y < 0) ? -int'(y) : int'(y);
        m  = ax | ay;
        s  = 0;
        if (m != 0) begin
            while (m < 16384) begin
                m = m * 2;
                s++;
            end
        end
        e.x     = x <<< s;
        e.y     = y <<< s;
        e.shift = 4'(s);
        e.zero  = ((ax | ay) == 0);
        return e;
    endfunction

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!s_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("s_ready_idle", 32'(s_ready), 32'd1);
    endtask

    task automatic run_pair(input logic signed [15:0] x, input logic signed [15:0] y, input int hold);
        exp_t e;
        int   cyc;
        sb.push_back(model(x, y));
        m_ready = (hold == 0);
        wait_ready();
        s_x = x; s_y = y; s_valid = 1'b1;
        @(posedge clk);
        #1 s_valid = 1'b0; s_x = '0; s_y = '0;
        @(negedge clk);
        check("s_ready_busy", 32'(s_ready), 32'd0);
        cyc = 1;
        while (!m_valid && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        check("latency", 32'(cyc), 32'd3);
        e = sb.pop_front();
        check("m_x",     32'(m_x),     32'(e.x));
        check("m_y",     32'(m_y),     32'(e.y));
        check("m_shift", 32'(m_shift), 32'(e.shift));
        check("m_zero",  32'(m_zero),  32'(e.zero));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_m_valid", 32'(m_valid), 32'd1);
            check("hold_m_x",     32'(m_x),     32'(e.x));
            check("hold_m_shift", 32'(m_shift), 32'(e.shift));
            check("hold_s_ready", 32'(s_ready), 32'd0);
        end
        m_ready = 1'b1;
        @(negedge clk);
        check("s_ready_after_hs", 32'(s_ready), 32'd1);
        check("m_valid_after_hs", 32'(m_valid), 32'd0);
    endtask

    initial begin
        logic signed [15:0] rx, ry;
        rst = 1'b1; s_valid = 1'b0; s_x = '0; s_y = '0; m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_x",     32'(m_x),     32'd0);
        check("rst_m_shift", 32'(m_shift), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("s_ready_pre_clk", 32'(s_ready), 32'd0);
        @(posedge clk);
        #1 check("s_ready_post_rst", 32'(s_ready), 32'd1);

        run_pair(16'sd1, 16'sd0, 0);
        run_pair(-16'sd3, 16'sd2, 0);
        run_pair(16'sd0, 16'sd0, 0);
        run_pair(-16'sd32768, 16'sd5, 0);
        run_pair(16'sd16384, -16'sd1, 0);
        run_pair(-16'sd32768, -16'sd32768, 0);
        run_pair(16'sd1, 16'sd0, 5);
        run_pair(16'sd100, -16'sd7, 0);

        // Reset while the pair sits in SHIFT; previous outputs are still nonzero.
        wait_ready();
        s_x = 16'sd5; s_y = 16'sd3; s_valid = 1'b1;
        @(posedge clk);
        #1 s_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_m_valid", 32'(m_valid), 32'd0);
        check("midrst_m_x",     32'(m_x),     32'd0);
        check("midrst_m_y",     32'(m_y),     32'd0);
        check("midrst_m_shift", 32'(m_shift), 32'd0);
        check("midrst_m_zero",  32'(m_zero),  32'd0);
        check("midrst_s_ready", 32'(s_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 check("midrst_s_ready_back", 32'(s_ready), 32'd1);
        run_pair(16'sd7, -16'sd9, 0);

        for (int i = 0; i < 8; i++) begin
            rx = 16'($urandom);
            ry = 16'($urandom);
            rx = rx >>> $urandom_range(0, 15);
            ry = ry >>> $urandom_range(0, 15);
            run_pair(rx, ry, (i == 3) ? 2 : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cordic_autoscale_ctrl.md
# cordic_autoscale_ctrl

Sequencing controller for the leading-one detector in the CORDIC arctan autoscale path. Accepts a signed (x, y) pair, finds the highest set bit of the combined magnitude, and left-shifts both operands by a common amount so the larger magnitude fills the word below the sign bit. It reports the applied shift so downstream logic can undo it. It sits between the sample source and the CORDIC arctan core and uses a valid/ready handshake on both sides.

## Interface
Parameters:
- DIN_WIDTH, 16: signed operand width in bits.
- SHIFT_WIDTH, $clog2(DIN_WIDTH): width of the reported shift and of the leading-one index.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- s_x, s_y  input  DIN_WIDTH  signed input operands.
- s_valid  input  1  input pair valid.
- s_ready  output  1  controller can accept a pair.
- m_x, m_y  output  DIN_WIDTH  signed scaled operands.
- m_shift  output  SHIFT_WIDTH  left-shift applied to both operands.
- m_zero  output  1  both inputs were zero.
- m_valid  output  1  output pair valid.
- m_ready  input  1  downstream accepts the output.

## Operation
- FSM states: IDLE, FIND, SHIFT, OUT.
- IDLE: s_ready=1. On s_valid&&s_ready, register s_x and s_y. Register mag = |s_x| | |s_y| as an unsigned DIN_WIDTH value, where |−2^(N−1)| = 2^(N−1). Go to FIND.
- FIND: the encoder registers p, the index of the highest set bit of mag, and a zero flag. Go to SHIFT.
- SHIFT: shift = (DIN_WIDTH−2) − p, clamped to 0 when p = DIN_WIDTH−1. Shift is forced to 0 when mag = 0. Register m_x = x<<<shift, m_y = y<<<shift, m_shift, and m_zero. Go to OUT.
- OUT: m_valid=1. Outputs are held stable until m_ready. On m_valid&&m_ready, go to IDLE.
- The shift never overflows: |v| < 2^(p+1), so the sign is preserved after shifting.
- s_ready is high only in IDLE. No input pair is accepted while a result is pending.

## Timing
- Reset values: s_ready=0 while rst is high, then 1 on the first clock after release. m_valid=0, m_x=m_y=0, m_shift=0, m_zero=0. State is IDLE.
- Latency: m_valid rises 3 cycles after the input handshake cycle.
- Minimum spacing between accepted pairs is 4 cycles: accept, FIND, SHIFT, OUT with immediate m_ready. s_ready is reasserted the cycle after the output handshake.
- m_ready held low: outputs and m_valid are frozen indefinitely. m_ready is ignored outside OUT.
- rst asserted in any state, including mid-FIND or mid-SHIFT: the pending pair is discarded and all outputs return to reset values immediately.

## Configuration
- AUTOSCALE_BYPASS_EN defined: adds input port `bypass` (1 bit), sampled together with the input pair. When it is 1, the pair passes through with shift 0 and the same 3-cycle latency. m_zero is still computed.
- AUTOSCALE_BYPASS_EN undefined: no `bypass` port; scaling is always applied.

## Structure
- The shared package holds the FSM state enum (IDLE/FIND/SHIFT/OUT, 2-bit encoding) and the derived constant MSB_TARGET = DIN_WIDTH−2.
- Sub-module: lead_one_encoder. It is a registered, 1-cycle-latency highest-set-bit encoder (DIN_WIDTH in, SHIFT_WIDTH index out, plus a zero flag), instantiated once for the FIND stage.

## Test plan
All cases use DIN_WIDTH=16 and m_ready=1 unless noted.
- x=1, y=0 -> m_shift=14, m_x=16384, m_y=0, m_zero=0, m_valid 3 cycles after accept.
- x=−3, y=2 -> mag=3, p=1, m_shift=13, m_x=−24576, m_y=16384.
- x=0, y=0 -> m_shift=0, m_x=m_y=0, m_zero=1.
- x=−32768, y=5 -> p=15, shift clamped, m_shift=0, m_x=−32768, m_y=5.
- Backpressure: x=1, y=0 with m_ready low for 5 cycles in OUT -> outputs stable, s_ready=0. The handshake completes on the cycle m_ready rises, and s_ready=1 the next cycle.
- Reset during SHIFT -> m_valid=0, all outputs zero, and a new pair is accepted right after rst deasserts.
